// File: rtl/timer_ctrl.sv
// Millisecond countdown timer with start/pause/clear control, driven by a 1 kHz ms_clk.
// Optional AUTO_RELOAD_EN: on expiry reload from load_val and keep running.
module timer_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ms_clk,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] remaining,
    output logic             running,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] remaining_reg, remaining_next;
    logic             done_reg, done_next;
    logic             ms_clk_d_reg;
    logic             pause_d_reg;
    logic             ms_tick;
    logic             pause_rise;

    assign ms_tick    = ms_clk & ~ms_clk_d_reg;
    assign pause_rise = pause & ~pause_d_reg;

    // ms_clk_d resets high so a high ms_clk at reset release is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            done_reg      <= 1'b0;
            ms_clk_d_reg  <= 1'b1;
            pause_d_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            done_reg      <= done_next;
            ms_clk_d_reg  <= ms_clk;
            pause_d_reg   <= pause;
        end
    end

    // Commands are mutually prioritised and any accepted command swallows a coincident tick.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        done_next      = 1'b0;
        if (clear) begin
            state_next     = IDLE;
            remaining_next = '0;
        end else if (start) begin
            if (load_val == '0) begin
                state_next     = EXPIRED;
                remaining_next = '0;
                done_next      = 1'b1;
            end else begin
                state_next     = RUN;
                remaining_next = load_val;
            end
        end else if (pause_rise && state_reg == RUN) begin
            state_next = PAUSED;
        end else if (pause_rise && state_reg == PAUSED) begin
            state_next = RUN;
        end else if (ms_tick && state_reg == RUN) begin
            if (remaining_reg > WIDTH'(1)) begin
                remaining_next = remaining_reg - WIDTH'(1);
            end else begin
                done_next = 1'b1;
`ifdef AUTO_RELOAD_EN
                if (load_val == '0) begin
                    state_next     = EXPIRED;
                    remaining_next = '0;
                end else begin
                    remaining_next = load_val;
                end
`else
                state_next     = EXPIRED;
                remaining_next = '0;
`endif
            end
        end
    end

    assign remaining = remaining_reg;
    assign done      = done_reg;
    assign state     = state_reg;
    assign running   = (state_reg == RUN);

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl; expected values are hand-computed per scenario.
module tb_timer_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ms_clk;
    logic             start;
    logic             pause;
    logic             clear;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] remaining;
    logic             running;
    logic             done;
    logic [1:0]       state;

    int total_cnt  = 0;
    int passed_cnt = 0;

    timer_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ms_clk    (ms_clk),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .load_val  (load_val),
        .remaining (remaining),
        .running   (running),
        .done      (done),
        .state     (state)
    );

    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            passed_cnt++;
            $display("check %-24s got %0d expected %0d ok", tag, got, exp);
        end else begin
            $display("FAIL %-24s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One ms_clk rising edge: check the edge result, then drop ms_clk and check done is gone.
    task automatic tick_chk(input string tag, input int exp_rem, input logic exp_done,
                            input logic [1:0] exp_state);
        ms_clk = 1'b1;
        cyc();
        check_val({tag, "_rem"}, 32'(remaining), 32'(exp_rem));
        check_val({tag, "_done"}, 32'(done), 32'(exp_done));
        check_val({tag, "_state"}, 32'(state), 32'(exp_state));
        ms_clk = 1'b0;
        cyc();
        check_val({tag, "_done_lo"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ms_clk   = 1'b1;
        start    = 1'b0;
        pause    = 1'b0;
        clear    = 1'b0;
        load_val = '0;
        cyc();
        cyc();
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_rem", 32'(remaining), 32'd0);
        check_val("rst_running", 32'(running), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        cyc();
        check_val("rel_no_tick_state", 32'(state), 32'd0);
        ms_clk = 1'b0;
        cyc();

        // Basic countdown 3,2,1,0 then EXPIRED
        load_val = 16'd3;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        check_val("t1_load_rem", 32'(remaining), 32'd3);
        check_val("t1_running", 32'(running), 32'd1);
        ms_clk = 1'b1;
        cyc();
        check_val("t1_tick1_rem", 32'(remaining), 32'd2);
        cyc();
        check_val("t1_held_high_rem", 32'(remaining), 32'd2);
        ms_clk = 1'b0;
        cyc();
        tick_chk("t1_tick2", 1, 1'b0, 2'd1);
        tick_chk("t1_tick3", 0, 1'b1, 2'd3);
        check_val("t1_exp_running", 32'(running), 32'd0);
        tick_chk("t1_tick_exp", 0, 1'b0, 2'd3);

        // Pause / resume
        load_val = 16'd5;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        tick_chk("t2_a1", 4, 1'b0, 2'd1);
        tick_chk("t2_a2", 3, 1'b0, 2'd1);
        pause = 1'b1;
        cyc();
        check_val("t2_paused", 32'(state), 32'd2);
        cyc();
        check_val("t2_pause_held", 32'(state), 32'd2);
        pause = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) tick_chk("t2_p", 3, 1'b0, 2'd2);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check_val("t2_resumed", 32'(state), 32'd1);
        cyc();
        tick_chk("t2_b1", 2, 1'b0, 2'd1);
        tick_chk("t2_b2", 1, 1'b0, 2'd1);
        tick_chk("t2_b3", 0, 1'b1, 2'd3);

        // Priority: start beats pause and tick; clear beats everything
        load_val = 16'd7;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        check_val("t3_rem7", 32'(remaining), 32'd7);
        load_val = 16'd9;
        start    = 1'b1;
        pause    = 1'b1;
        ms_clk   = 1'b1;
        cyc();
        start  = 1'b0;
        pause  = 1'b0;
        ms_clk = 1'b0;
        check_val("t3_restart_rem", 32'(remaining), 32'd9);
        check_val("t3_restart_state", 32'(state), 32'd1);
        cyc();
        clear  = 1'b1;
        start  = 1'b1;
        pause  = 1'b1;
        ms_clk = 1'b1;
        cyc();
        clear  = 1'b0;
        start  = 1'b0;
        pause  = 1'b0;
        ms_clk = 1'b0;
        check_val("t3_clear_state", 32'(state), 32'd0);
        check_val("t3_clear_rem", 32'(remaining), 32'd0);
        check_val("t3_clear_done", 32'(done), 32'd0);
        cyc();
        tick_chk("t3_idle_tick", 0, 1'b0, 2'd0);

        // Zero load goes straight to EXPIRED with done
        load_val = 16'd0;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        check_val("t4_state", 32'(state), 32'd3);
        check_val("t4_done", 32'(done), 32'd1);
        cyc();
        check_val("t4_done_lo", 32'(done), 32'd0);
        tick_chk("t4_tick", 0, 1'b0, 2'd3);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check_val("t4_pause_ign", 32'(state), 32'd3);
        cyc();

        // Reset mid-countdown, released with ms_clk high
        load_val = 16'd4;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        tick_chk("t5_a1", 3, 1'b0, 2'd1);
        tick_chk("t5_a2", 2, 1'b0, 2'd1);
        ms_clk = 1'b1;
        rst_n  = 1'b0;
        #1;
        check_val("t5_async_state", 32'(state), 32'd0);
        check_val("t5_async_rem", 32'(remaining), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check_val("t5_post_rem", 32'(remaining), 32'd0);
        check_val("t5_post_state", 32'(state), 32'd0);
        check_val("t5_post_done", 32'(done), 32'd0);
        ms_clk = 1'b0;
        cyc();

`ifdef AUTO_RELOAD_EN
        load_val = 16'd2;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        check_val("t6_load_rem", 32'(remaining), 32'd2);
        for (int i = 1; i <= 6; i++) begin
            tick_chk("t6_tick", (i % 2 == 1) ? 1 : 2, (i % 2 == 0), 2'd1);
        end
`else
        load_val = 16'd1;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        tick_chk("t6_one_expire", 0, 1'b1, 2'd3);
        load_val = 16'd2;
        tick_chk("t6_stays_exp", 0, 1'b0, 2'd3);
`endif

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
- REQ-001: Parameter WIDTH, default 16, bit width of load_val and remaining (ms units).
- REQ-002: clk  input  1  system clock (50 MHz); all logic on rising edge.
- REQ-003: rst_n  input  1  asynchronous, active-low reset.
- REQ-004: ms_clk  input  1  1 kHz square wave from the clock divider, synchronous to clk, resets high.
- REQ-005: start  input  1  level-sampled; loads load_val and begins countdown.
- REQ-006: pause  input  1  level-sampled; toggles RUN <-> PAUSED.
- REQ-007: clear  input  1  level-sampled; abort, return to IDLE.
- REQ-008: load_val  input  WIDTH  countdown start value in ms, captured on accepted start.
- REQ-009: remaining  output  WIDTH  registered ms left.
- REQ-010: running  output  1  high when state is RUN.
- REQ-011: done  output  1  one-cycle pulse on expiry.
- REQ-012: state  output  2  IDLE=0, RUN=1, PAUSED=2, EXPIRED=3.

Function
- REQ-013: Block SHALL register ms_clk into ms_clk_d and form ms_tick = ms_clk AND NOT ms_clk_d, one tick per ms_clk rising edge, one clk cycle wide.
- REQ-014: Command priority SHALL be clear > start > pause when asserted in the same cycle.
- REQ-015: clear in any state SHALL set state IDLE, remaining 0, done 0 on the next edge.
- REQ-016: start in IDLE, PAUSED or EXPIRED SHALL load remaining = load_val and enter RUN next edge; start in RUN SHALL restart from load_val.
- REQ-017: start with load_val = 0 SHALL enter EXPIRED directly and pulse done on that same edge.
- REQ-018: pause in RUN SHALL enter PAUSED; pause in PAUSED SHALL enter RUN; pause in IDLE or EXPIRED SHALL be ignored.
- REQ-019: pause SHALL act on its rising edge only (internally registered); held pause SHALL NOT toggle repeatedly.
- REQ-020: In RUN, ms_tick with remaining > 1 SHALL decrement remaining by 1 on that edge.
- REQ-021: In RUN, ms_tick with remaining = 1 SHALL set remaining 0, assert done for exactly one cycle, and take the expiry action of REQ-029/030 on the same edge.
- REQ-022: ms_tick in IDLE, PAUSED or EXPIRED SHALL NOT change remaining.
- REQ-023: ms_tick coinciding with an accepted command SHALL be discarded; the command wins.
- REQ-024: remaining SHALL never wrap below 0.
- REQ-025: done SHALL be 0 in every cycle not covered by REQ-017/REQ-021.

Reset
- REQ-026: Asserting rst_n low SHALL asynchronously force state IDLE, remaining 0, running 0, done 0, pause edge register 0.
- REQ-027: ms_clk_d SHALL reset to 1 so no spurious tick follows reset release while ms_clk is high.
- REQ-028: Reset mid-countdown SHALL discard the count; no done pulse SHALL be emitted.

Configuration
- REQ-029: With AUTO_RELOAD_EN defined, expiry SHALL reload remaining = load_val (current input), remain in RUN, and still pulse done; a reload value of 0 SHALL enter EXPIRED instead.
- REQ-030: Without AUTO_RELOAD_EN, expiry SHALL enter EXPIRED with remaining 0 and running 0 until start or clear.

Verification
- REQ-031: load_val=3, start 1 cycle, 3 ms_clk rising edges -> remaining 3,2,1,0; done one cycle on third tick; state=3 (macro off).
- REQ-032: load_val=5, start, 2 ticks, pause pulse, 4 ticks, pause pulse, 3 ticks -> remaining holds 3 while PAUSED, then reaches 0 with single done.
- REQ-033: start, clear, pause asserted together in RUN with remaining=7 -> IDLE, remaining 0, no done.
- REQ-034: load_val=0, start -> EXPIRED and done same edge; subsequent ticks leave remaining 0.
- REQ-035: load_val=4, start, 2 ticks, rst_n low 1 cycle, release with ms_clk high -> IDLE, remaining 0, no done, no decrement on first cycle.
- REQ-036: AUTO_RELOAD_EN defined, load_val=2, 6 ticks -> done on ticks 2, 4, 6; state stays RUN; remaining 2,1,2,1,2,1,2.
